miriscv_lsu: RTL and testbench
==============================

Name: miriscv_lsu

Overview:
Load/store unit: the initiator side of the core's data-memory interface (req/we/be/addr/wdata/rdata). It turns core load/store requests into byte-enabled word transactions to the RAM and stalls the core until each access completes. It aligns store data, extracts and sign- or zero-extends load data, and splits accesses that cross a word boundary into two memory beats. It sits between the execute stage and the data RAM.

Parameters:
SPLIT_MISALIGNED, 1, 1: split word-crossing accesses into two beats; 0: flag them as errors with no memory access.

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
lsu_req_i  in  1  core access request; held stable by core while lsu_stall_req_o=1
lsu_we_i  in  1  1=store, 0=load
lsu_size_i  in  3  funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
lsu_addr_i  in  32  byte address
lsu_data_i  in  32  store data, LSB-aligned
lsu_data_o  out  32  load result, extended; registered
lsu_stall_req_o  out  1  core must hold the pipeline
lsu_err_o  out  1  one-cycle pulse in DONE on a misaligned or invalid-size access
data_req_o  out  1  memory request
data_we_o  out  1  memory write enable
data_be_o  out  4  byte enables
data_addr_o  out  32  word address, bits [1:0] = 0
data_wdata_o  out  32  byte-lane-aligned write data
data_rdata_i  in  32  memory read data; combinational, same cycle as address

Behaviour:
- Reset, synchronous on rst_i=1: state IDLE; lsu_data_o=0; lsu_err_o=0; data_req_o=0; data_we_o=0; data_be_o=0; data_addr_o=0; data_wdata_o=0; lsu_stall_req_o=0 while rst_i=1.
- States: IDLE, BEAT1, BEAT2, DONE.
- Definitions: off = lsu_addr_i[1:0]; mask = 0001 (B/BU), 0011 (H/HU), 1111 (W); wide_be = {4'b0, mask} << off (8 bits); wide_wd = {32'b0, lsu_data_i} << (8*off) (64 bits); cross = wide_be[7:4] != 0.
- lsu_stall_req_o = lsu_req_i && state != DONE. This is combinational, so it asserts in the same cycle as the request.
- IDLE with lsu_req_i=1:
  - Invalid size, or cross with SPLIT_MISALIGNED=0: go to DONE with no data_req_o and lsu_err_o=1 in DONE.
  - Otherwise: enter BEAT1.
- BEAT1: data_req_o=1, data_addr_o={addr[31:2],2'b00}, data_be_o=wide_be[3:0], data_wdata_o=wide_wd[31:0], data_we_o=lsu_we_i. Capture data_rdata_i into lo_q. Next state is BEAT2 if cross, else DONE.
- BEAT2: data_addr_o = word address + 4, wrapping modulo 2^32. data_be_o=wide_be[7:4], data_wdata_o=wide_wd[63:32]. Capture data_rdata_i into hi_q. Next state is DONE.
- IDLE takes one cycle, so latency from request to the first cycle with stall low (DONE) is: 2 cycles for a non-crossing access (IDLE, BEAT1), 3 cycles for a crossing access (IDLE, BEAT1, BEAT2), 1 cycle for an error (IDLE).
- Loads: lsu_data_o is registered on entry to DONE.
  - raw = ({hi_q, lo_q} >> (8*off))[31:0]; hi_q = 0 when there is no BEAT2.
  - B/H: sign-extend bit 7 or bit 15. BU/HU: zero-extend.
  - lsu_data_o holds its value until the next load completes.
  - Stores do not modify lsu_data_o.
- DONE: data_req_o=0, lsu_stall_req_o=0, then return to IDLE. A lsu_req_i=1 seen in IDLE starts a new access. Back-to-back requests therefore take 3 cycles each for non-crossing accesses.
- data_* outputs other than data_req_o are don't-care when data_req_o=0, but they are driven to 0.
- Reset in BEAT1 or BEAT2 aborts the access: data_req_o=0 the next cycle and no second beat is issued. A store may be half-written; this is accepted.
- lsu_req_i dropping mid-access is illegal for the core; the LSU still completes the access.

Decomposition:
- miriscv_lsu_pkg holds:
  - size encodings LSU_B, LSU_H, LSU_W, LSU_BU, LSU_HU;
  - the state typedef;
  - the mask function.
- Sub-module miriscv_lsu_align (combinational): wide_be/wide_wd generation and load extract/extend. The FSM and registers stay in miriscv_lsu.

Test Plan:
1. Memory model: combinational read, byte-enable write on posedge with req.
2. LW addr 0x10, mem[4]=0xDEADBEEF -> one beat with be=1111, addr 0x10; lsu_data_o=0xDEADBEEF; stall high 2 cycles.
3. LB at 0x13 and LBU at 0x13, mem[4]=0x80xxxxxx -> be=1000; LB gives 0xFFFFFF80, LBU gives 0x00000080.
4. SH 0x1234 at 0x12 -> be=1100, wdata=0x12340000; mem[4][31:16]=0x1234 and the other bytes are unchanged.
5. LW at 0x13, mem[4]=0x44332211, mem[5]=0x88776655 -> beats at 0x10 (be=1000) then 0x14 (be=0111); lsu_data_o=0x77665544; stall high 3 cycles.
6. SPLIT_MISALIGNED=0 with SW at 0x02, plus size=011 with SPLIT_MISALIGNED=1 -> no data_req_o; lsu_err_o pulses in DONE; stall high 1 cycle. Separately, rst_i=1 during BEAT1 of a crossing SW -> no BEAT2 and mem[5] unchanged.

Source files
------------

// File: rtl/miriscv_lsu_pkg.sv
// rtl/miriscv_lsu_pkg.sv - shared size encodings, FSM states and byte-mask helper for the LSU
package miriscv_lsu_pkg;

    localparam logic [2:0] LSU_B  = 3'b000;
    localparam logic [2:0] LSU_H  = 3'b001;
    localparam logic [2:0] LSU_W  = 3'b010;
    localparam logic [2:0] LSU_BU = 3'b100;
    localparam logic [2:0] LSU_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BEAT1 = 2'd1,
        ST_BEAT2 = 2'd2,
        ST_DONE  = 2'd3
    } lsu_state_e;

    // An all-zero mask marks an unsupported funct3.
    function automatic logic [3:0] lsu_mask(input logic [2:0] size);
        case (size)
            LSU_B, LSU_BU: lsu_mask = 4'b0001;
            LSU_H, LSU_HU: lsu_mask = 4'b0011;
            LSU_W:         lsu_mask = 4'b1111;
            default:       lsu_mask = 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/miriscv_lsu_align.sv
// rtl/miriscv_lsu_align.sv - byte-lane alignment of store data and extraction/extension of load data
module miriscv_lsu_align
    import miriscv_lsu_pkg::*;
(
    input  logic [2:0]  i_size,
    input  logic [1:0]  i_off,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_lo,
    input  logic [31:0] i_hi,
    output logic        o_valid,
    output logic        o_cross,
    output logic [7:0]  o_wide_be,
    output logic [63:0] o_wide_wd,
    output logic [31:0] o_rdata
);

    logic [3:0]  w_mask;
    logic [63:0] w_raw64;
    logic [31:0] w_raw;

    always_comb begin
        w_mask    = lsu_mask(i_size);
        o_valid   = (w_mask != 4'b0000);
        o_wide_be = {4'b0000, w_mask} << i_off;
        o_wide_wd = {32'b0, i_wdata} << {i_off, 3'b000};
        o_cross   = (o_wide_be[7:4] != 4'b0000);
        w_raw64   = {i_hi, i_lo} >> {i_off, 3'b000};
        w_raw     = w_raw64[31:0];
        case (i_size)
            LSU_B:   o_rdata = {{24{w_raw[7]}}, w_raw[7:0]};
            LSU_H:   o_rdata = {{16{w_raw[15]}}, w_raw[15:0]};
            LSU_BU:  o_rdata = {24'b0, w_raw[7:0]};
            LSU_HU:  o_rdata = {16'b0, w_raw[15:0]};
            default: o_rdata = w_raw;
        endcase
    end

endmodule

// File: rtl/miriscv_lsu.sv
// rtl/miriscv_lsu.sv - load/store unit: core request to byte-enabled word beats on the data RAM port
module miriscv_lsu
    import miriscv_lsu_pkg::*;
#(
    parameter bit SPLIT_MISALIGNED = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        lsu_req_i,
    input  logic        lsu_we_i,
    input  logic [2:0]  lsu_size_i,
    input  logic [31:0] lsu_addr_i,
    input  logic [31:0] lsu_data_i,
    output logic [31:0] lsu_data_o,
    output logic        lsu_stall_req_o,
    output logic        lsu_err_o,
    output logic        data_req_o,
    output logic        data_we_o,
    output logic [3:0]  data_be_o,
    output logic [31:0] data_addr_o,
    output logic [31:0] data_wdata_o,
    input  logic [31:0] data_rdata_i
);

    lsu_state_e  r_state, w_next;
    logic [31:0] r_lo, r_data;
    logic        r_err;
    logic        w_valid, w_cross, w_bad;
    logic [7:0]  w_wide_be;
    logic [63:0] w_wide_wd;
    logic [31:0] w_lo, w_hi, w_ext, w_word;

    // RAM reads are combinational, so the beat that leads into DONE feeds the extender directly.
    assign w_lo   = (r_state == ST_BEAT1) ? data_rdata_i : r_lo;
    assign w_hi   = (r_state == ST_BEAT2) ? data_rdata_i : 32'b0;
    assign w_word = {lsu_addr_i[31:2], 2'b00};
    assign w_bad  = !w_valid || (w_cross && !SPLIT_MISALIGNED);

    miriscv_lsu_align u_align (
        .i_size    (lsu_size_i),
        .i_off     (lsu_addr_i[1:0]),
        .i_wdata   (lsu_data_i),
        .i_lo      (w_lo),
        .i_hi      (w_hi),
        .o_valid   (w_valid),
        .o_cross   (w_cross),
        .o_wide_be (w_wide_be),
        .o_wide_wd (w_wide_wd),
        .o_rdata   (w_ext)
    );

    always_comb begin
        w_next       = r_state;
        data_req_o   = 1'b0;
        data_we_o    = 1'b0;
        data_be_o    = 4'b0000;
        data_addr_o  = 32'b0;
        data_wdata_o = 32'b0;
        case (r_state)
            ST_IDLE: begin
                if (lsu_req_i) w_next = w_bad ? ST_DONE : ST_BEAT1;
            end
            ST_BEAT1: begin
                data_req_o   = 1'b1;
                data_we_o    = lsu_we_i;
                data_be_o    = w_wide_be[3:0];
                data_addr_o  = w_word;
                data_wdata_o = w_wide_wd[31:0];
                w_next       = w_cross ? ST_BEAT2 : ST_DONE;
            end
            ST_BEAT2: begin
                data_req_o   = 1'b1;
                data_we_o    = lsu_we_i;
                data_be_o    = w_wide_be[7:4];
                data_addr_o  = w_word + 32'd4;
                data_wdata_o = w_wide_wd[63:32];
                w_next       = ST_DONE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
            r_lo    <= 32'b0;
            r_data  <= 32'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_err   <= (r_state == ST_IDLE) && lsu_req_i && w_bad;
            if (r_state == ST_BEAT1) r_lo <= data_rdata_i;
            if ((r_state == ST_BEAT1 || r_state == ST_BEAT2) && w_next == ST_DONE && !lsu_we_i)
                r_data <= w_ext;
        end
    end

    assign lsu_data_o      = r_data;
    assign lsu_err_o       = r_err;
    assign lsu_stall_req_o = lsu_req_i && (r_state != ST_DONE) && !rst_i;

endmodule

// File: tb/tb_miriscv_lsu.sv
// tb/tb_miriscv_lsu.sv - scoreboard bench for miriscv_lsu with a byte-enable RAM model
module tb_miriscv_lsu;
    import miriscv_lsu_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, req, req0, we;
    logic [2:0]  size;
    logic [31:0] addr, wdat;

    logic [31:0] lsu_data, d_addr, d_wdata, rdata;
    logic        stall, err, d_req, d_we;
    logic [3:0]  d_be;

    logic [31:0] lsu_data0, d0_addr, d0_wdata;
    logic        stall0, err0, d0_req, d0_we;
    logic [3:0]  d0_be;

    logic [31:0] mem [0:15];

    miriscv_lsu #(.SPLIT_MISALIGNED(1'b1)) u_dut (
        .clk_i(clk), .rst_i(rst), .lsu_req_i(req), .lsu_we_i(we), .lsu_size_i(size),
        .lsu_addr_i(addr), .lsu_data_i(wdat), .lsu_data_o(lsu_data), .lsu_stall_req_o(stall),
        .lsu_err_o(err), .data_req_o(d_req), .data_we_o(d_we), .data_be_o(d_be),
        .data_addr_o(d_addr), .data_wdata_o(d_wdata), .data_rdata_i(rdata)
    );

    miriscv_lsu #(.SPLIT_MISALIGNED(1'b0)) u_dut_nosplit (
        .clk_i(clk), .rst_i(rst), .lsu_req_i(req0), .lsu_we_i(we), .lsu_size_i(size),
        .lsu_addr_i(addr), .lsu_data_i(wdat), .lsu_data_o(lsu_data0), .lsu_stall_req_o(stall0),
        .lsu_err_o(err0), .data_req_o(d0_req), .data_we_o(d0_we), .data_be_o(d0_be),
        .data_addr_o(d0_addr), .data_wdata_o(d0_wdata), .data_rdata_i(32'h5A5A5A5A)
    );

    assign rdata = mem[d_addr[5:2]];
    always @(posedge clk) begin
        if (d_req && d_we)
            for (int b = 0; b < 4; b++)
                if (d_be[b]) mem[d_addr[5:2]][8*b +: 8] <= d_wdata[8*b +: 8];
    end

    typedef struct { logic [31:0] addr; logic [3:0] be; logic we; logic [31:0] wdata; } beat_t;
    typedef struct { logic [31:0] data; logic err; int stalls; } done_t;
    beat_t beat_q[$];
    done_t done_q[$];
    beat_t mb;
    done_t md;
    int total = 0, bad = 0, stall_cnt = 0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_beat(input logic [31:0] a, input logic [3:0] be, input logic w, input logic [31:0] wd);
        beat_q.push_back('{a, be, w, wd});
    endtask

    task automatic push_done(input logic [31:0] d, input logic e, input int st);
        done_q.push_back('{d, e, st});
    endtask

    always @(negedge clk) begin
        if (d_req) begin
            if (beat_q.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_beat: got addr %h be %b expected none", d_addr, d_be);
            end else begin
                mb = beat_q.pop_front();
                check32("beat_addr", d_addr, mb.addr);
                check32("beat_be", {28'b0, d_be}, {28'b0, mb.be});
                check32("beat_we", {31'b0, d_we}, {31'b0, mb.we});
                check32("beat_wdata", d_wdata, mb.wdata);
            end
        end
        if (rst) stall_cnt = 0;
        else if (req) begin
            if (stall) stall_cnt++;
            else begin
                if (done_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_done: got data %h expected none", lsu_data);
                end else begin
                    md = done_q.pop_front();
                    check32("done_data", lsu_data, md.data);
                    check32("done_err", {31'b0, err}, {31'b0, md.err});
                    check32("done_stalls", stall_cnt, md.stalls);
                end
                stall_cnt = 0;
            end
        end
    end

    // Called just after a posedge; returns just after the posedge that leaves DONE.
    task automatic access(input logic w, input logic [2:0] sz, input logic [31:0] a, input logic [31:0] d);
        int n;
        we = w; size = sz; addr = a; wdat = d; req = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (stall && n < 10);
        if (stall) begin
            total++; bad++;
            $display("FAIL access_timeout: got stall 1 expected 0 after %0d cycles", n);
        end
        @(posedge clk); #1;
        req = 1'b0; we = 1'b0; wdat = 32'b0;
    endtask

    task automatic access0(input logic w, input logic [2:0] sz, input logic [31:0] a,
                           input int exp_reqs, input logic exp_err, input int exp_stalls);
        int n, reqs;
        we = w; size = sz; addr = a; wdat = 32'h0BAD_F00D; req0 = 1'b1;
        n = 0; reqs = 0;
        do begin
            @(negedge clk);
            if (d0_req) reqs++;
            if (stall0) n++;
        end while (stall0 && n < 10);
        check32("nosplit_stalls", n, exp_stalls);
        check32("nosplit_reqs", reqs, exp_reqs);
        check32("nosplit_err", {31'b0, err0}, {31'b0, exp_err});
        @(posedge clk); #1;
        req0 = 1'b0; we = 1'b0; wdat = 32'b0;
        @(negedge clk);
        check32("nosplit_err_pulse", {31'b0, err0}, 32'b0);
        @(posedge clk); #1;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 32'b0;
        rst = 1'b1; req = 1'b0; req0 = 1'b0; we = 1'b0; size = LSU_W; addr = 32'b0; wdat = 32'b0;
        repeat (2) @(posedge clk);
        #1 req = 1'b1;
        @(negedge clk);
        check32("rst_stall", {31'b0, stall}, 32'b0);
        check32("rst_req", {31'b0, d_req}, 32'b0);
        check32("rst_data", lsu_data, 32'b0);
        check32("rst_err", {31'b0, err}, 32'b0);
        check32("rst_be_addr_wdata", {28'b0, d_be} | d_addr | d_wdata, 32'b0);
        @(posedge clk); #1;
        rst = 1'b0; req = 1'b0;
        @(posedge clk); #1;

        mem[4] = 32'hDEADBEEF;
        push_beat(32'h10, 4'b1111, 1'b0, 32'h0); push_done(32'hDEADBEEF, 1'b0, 2);
        access(1'b0, LSU_W, 32'h10, 32'h0);

        mem[4] = 32'h80112233;
        push_beat(32'h10, 4'b1000, 1'b0, 32'h0); push_done(32'hFFFFFF80, 1'b0, 2);
        access(1'b0, LSU_B, 32'h13, 32'h0);
        push_beat(32'h10, 4'b1000, 1'b0, 32'h0); push_done(32'h00000080, 1'b0, 2);
        access(1'b0, LSU_BU, 32'h13, 32'h0);
        push_beat(32'h10, 4'b1100, 1'b0, 32'h0); push_done(32'hFFFF8011, 1'b0, 2);
        access(1'b0, LSU_H, 32'h12, 32'h0);
        push_beat(32'h10, 4'b0110, 1'b0, 32'h0); push_done(32'h00001122, 1'b0, 2);
        access(1'b0, LSU_HU, 32'h11, 32'h0);

        mem[4] = 32'hAABBCCDD;
        push_beat(32'h10, 4'b1100, 1'b1, 32'h12340000); push_done(32'h00001122, 1'b0, 2);
        access(1'b1, LSU_H, 32'h12, 32'h00001234);
        check32("sh_mem4", mem[4], 32'h1234CCDD);

        mem[4] = 32'h44332211; mem[5] = 32'h88776655;
        push_beat(32'h10, 4'b1000, 1'b0, 32'h0); push_beat(32'h14, 4'b0111, 1'b0, 32'h0);
        push_done(32'h77665544, 1'b0, 3);
        access(1'b0, LSU_W, 32'h13, 32'h0);

        push_beat(32'h14, 4'b1100, 1'b1, 32'hBABE0000); push_beat(32'h18, 4'b0011, 1'b1, 32'h0000CAFE);
        push_done(32'h77665544, 1'b0, 3);
        access(1'b1, LSU_W, 32'h16, 32'hCAFEBABE);
        check32("sw_cross_mem5", mem[5], 32'hBABE6655);
        check32("sw_cross_mem6", mem[6], 32'h0000CAFE);

        mem[15] = 32'hAB000000; mem[0] = 32'h000000CD;
        push_beat(32'hFFFFFFFC, 4'b1000, 1'b0, 32'h0); push_beat(32'h0, 4'b0001, 1'b0, 32'h0);
        push_done(32'hFFFFCDAB, 1'b0, 3);
        access(1'b0, LSU_H, 32'hFFFFFFFF, 32'h0);

        push_done(32'hFFFFCDAB, 1'b1, 1);
        access(1'b0, 3'b011, 32'h10, 32'h0);
        push_done(32'hFFFFCDAB, 1'b1, 1);
        access(1'b1, 3'b110, 32'h00, 32'h11111111);
        check32("bad_size_store_mem0", mem[0], 32'h000000CD);

        access0(1'b1, LSU_W, 32'h02, 0, 1'b1, 1);
        access0(1'b0, LSU_W, 32'h08, 1, 1'b0, 2);
        check32("nosplit_lw_data", lsu_data0, 32'h5A5A5A5A);

        push_beat(32'h10, 4'b1000, 1'b1, 32'h44000000);
        we = 1'b1; size = LSU_W; addr = 32'h13; wdat = 32'h11223344; req = 1'b1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; req = 1'b0; we = 1'b0; wdat = 32'b0;
        repeat (4) @(posedge clk);
        #1;
        check32("abort_mem5", mem[5], 32'hBABE6655);
        check32("abort_beats_left", beat_q.size(), 32'd0);
        check32("abort_done_left", done_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
